// File: rtl/cpu_pkg.sv
// cpu_pkg: constants shared by the processor datapath and its instruction decoder.
//   DATA_W      register / bus data width
//   REG_ADDR_W  register index width (8 registers)
//   R0..R7      register-index constants used by the decoder and the register file
package cpu_pkg;

    localparam int DATA_W     = 8;
    localparam int REG_ADDR_W = 3;

    localparam logic [REG_ADDR_W-1:0] R0 = 3'd0;
    localparam logic [REG_ADDR_W-1:0] R1 = 3'd1;
    localparam logic [REG_ADDR_W-1:0] R2 = 3'd2;
    localparam logic [REG_ADDR_W-1:0] R3 = 3'd3;
    localparam logic [REG_ADDR_W-1:0] R4 = 3'd4;
    localparam logic [REG_ADDR_W-1:0] R5 = 3'd5;
    localparam logic [REG_ADDR_W-1:0] R6 = 3'd6;
    localparam logic [REG_ADDR_W-1:0] R7 = 3'd7;

endpackage

// File: rtl/reg_read_port.sv
// reg_read_port: one asynchronous read port of the register file.
//   regs_i     flattened register array contents
//   rd_addr_i  register index to read
//   wr_addr_i  index being written this cycle (for forwarding)
//   wr_data_i  data being written this cycle (for forwarding)
//   wr_fire_i  a write will commit on the coming edge (WRITE & ~BUSYWAIT & ~RESET)
//   rd_data_o  read data
module reg_read_port #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 3,
    parameter int FORWARD = 0,
    parameter int ZERO_R0 = 0
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs_i,
    input  logic [ADDR_W-1:0]                  rd_addr_i,
    input  logic [ADDR_W-1:0]                  wr_addr_i,
    input  logic [DATA_W-1:0]                  wr_data_i,
    input  logic                               wr_fire_i,
    output logic [DATA_W-1:0]                  rd_data_o
);

    always_comb begin
        rd_data_o = regs_i[rd_addr_i];
        // Bypass the value that will be stored on the coming edge.
        if (FORWARD != 0 && wr_fire_i && (rd_addr_i == wr_addr_i)) begin
            rd_data_o = wr_data_i;
        end
        // Hardwired zero wins over forwarding.
        if (ZERO_R0 != 0 && (rd_addr_i == ADDR_W'(cpu_pkg::R0))) begin
            rd_data_o = '0;
        end
    end

endmodule

// File: rtl/reg_file_8x8.sv
// reg_file_8x8: 8 x 8-bit register file, two async read ports, one write port.
//   CLK          clock; writes on rising edge
//   RESET        asynchronous active-high clear of every register
//   IN           write-back data
//   INADDRESS    write address
//   WRITE        write enable
//   BUSYWAIT     memory stall; blocks writes (and forwarding) while high
//   OUT1ADDRESS  read port 1 address     OUT1  read port 1 data
//   OUT2ADDRESS  read port 2 address     OUT2  read port 2 data
module reg_file_8x8 #(
    parameter int DATA_W  = cpu_pkg::DATA_W,
    parameter int ADDR_W  = cpu_pkg::REG_ADDR_W,
    parameter int FORWARD = 0,
    parameter int ZERO_R0 = 0
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic              BUSYWAIT,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0][DATA_W-1:0] regs_d;
    logic [DEPTH-1:0]             wr_en;
    logic                         wr_fire;

    // RESET is included so forwarding is also suppressed while reset is held.
    assign wr_fire = WRITE && !BUSYWAIT && !RESET;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            // R0 is never written when it is hardwired to zero.
            assign wr_en[gi]  = wr_fire && (INADDRESS == ADDR_W'(gi))
                                && (ZERO_R0 == 0 || gi != 0);
            assign regs_d[gi] = wr_en[gi] ? IN : regs_q[gi];

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    regs_q[gi] <= '0;
                end else begin
                    regs_q[gi] <= regs_d[gi];
                end
            end
        end
    endgenerate

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FORWARD(FORWARD),
        .ZERO_R0(ZERO_R0)
    ) u_port1 (
        .regs_i   (regs_q),
        .rd_addr_i(OUT1ADDRESS),
        .wr_addr_i(INADDRESS),
        .wr_data_i(IN),
        .wr_fire_i(wr_fire),
        .rd_data_o(OUT1)
    );

    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .FORWARD(FORWARD),
        .ZERO_R0(ZERO_R0)
    ) u_port2 (
        .regs_i   (regs_q),
        .rd_addr_i(OUT2ADDRESS),
        .wr_addr_i(INADDRESS),
        .wr_data_i(IN),
        .wr_fire_i(wr_fire),
        .rd_data_o(OUT2)
    );

endmodule

// File: tb/tb_reg_file_8x8.sv
// Testbench for reg_file_8x8. Two instances share all inputs:
//   dut_a: FORWARD=0, ZERO_R0=0
//   dut_b: FORWARD=1, ZERO_R0=1
module tb_reg_file_8x8;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [2:0] waddr;
    logic       wr;
    logic       busy;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [7:0] out1_a, out2_a, out1_b, out2_b;

    int checks   = 0;
    int failures = 0;

    reg_file_8x8 #(.FORWARD(0), .ZERO_R0(0)) dut_a (
        .CLK(clk), .RESET(rst), .IN(din), .INADDRESS(waddr), .WRITE(wr),
        .BUSYWAIT(busy), .OUT1ADDRESS(a1), .OUT2ADDRESS(a2),
        .OUT1(out1_a), .OUT2(out2_a)
    );

    reg_file_8x8 #(.FORWARD(1), .ZERO_R0(1)) dut_b (
        .CLK(clk), .RESET(rst), .IN(din), .INADDRESS(waddr), .WRITE(wr),
        .BUSYWAIT(busy), .OUT1ADDRESS(a1), .OUT2ADDRESS(a2),
        .OUT1(out1_b), .OUT2(out2_b)
    );

    // Posedges at 5, 15, 25, ...; inputs change on negedges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       wr;
        logic       busy;
        logic [7:0] din;
        logic [2:0] waddr;
        logic [2:0] a1;
        logic [2:0] a2;
        logic [7:0] e1a;
        logic [7:0] e2a;
        logic [7:0] e1b;
        logic [7:0] e2b;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] e1a, input logic [7:0] e2a,
                             input logic [7:0] e1b, input logic [7:0] e2b);
        check({tag, " a.OUT1"}, out1_a, e1a);
        check({tag, " a.OUT2"}, out2_a, e2a);
        check({tag, " b.OUT1"}, out1_b, e1b);
        check({tag, " b.OUT2"}, out2_b, e2b);
    endtask

    initial begin
        // Expected values are the outputs seen just before the edge that applies the vector.
        //              wr    busy  din    wa    a1    a2    e1a    e2a    e1b    e2b
        vecs[0]  = '{1'b1, 1'b0, 8'h3C, 3'd5, 3'd5, 3'd2, 8'h00, 8'h00, 8'h3C, 8'h00};
        vecs[1]  = '{1'b1, 1'b0, 8'hF0, 3'd2, 3'd5, 3'd2, 8'h3C, 8'h00, 8'h3C, 8'hF0};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd5, 3'd2, 8'h3C, 8'hF0, 8'h3C, 8'hF0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd7, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd1, 3'd3, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd4, 3'd6, 8'h00, 8'h00, 8'h00, 8'h00};
        // stall for three edges, then release
        vecs[6]  = '{1'b1, 1'b1, 8'h77, 3'd4, 3'd4, 3'd4, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[7]  = '{1'b1, 1'b1, 8'h77, 3'd4, 3'd4, 3'd4, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[8]  = '{1'b1, 1'b1, 8'h77, 3'd4, 3'd4, 3'd4, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[9]  = '{1'b1, 1'b0, 8'h77, 3'd4, 3'd4, 3'd4, 8'h00, 8'h00, 8'h77, 8'h77};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd4, 3'd5, 8'h77, 8'h3C, 8'h77, 8'h3C};
        // forwarding over a stored value
        vecs[11] = '{1'b1, 1'b0, 8'h11, 3'd1, 3'd1, 3'd0, 8'h00, 8'h00, 8'h11, 8'h00};
        vecs[12] = '{1'b1, 1'b0, 8'h22, 3'd1, 3'd1, 3'd1, 8'h11, 8'h11, 8'h22, 8'h22};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd1, 3'd2, 8'h22, 8'hF0, 8'h22, 8'hF0};
        // write to R0
        vecs[14] = '{1'b1, 1'b0, 8'hFF, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[15] = '{1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 3'd0, 8'hFF, 8'hFF, 8'h00, 8'h00};

        rst = 1'b1; wr = 1'b0; busy = 1'b0; din = 8'h00; waddr = 3'd0; a1 = 3'd0; a2 = 3'd7;
        #1;
        check_all("reset", 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            wr = vecs[i].wr; busy = vecs[i].busy; din = vecs[i].din; waddr = vecs[i].waddr;
            a1 = vecs[i].a1; a2 = vecs[i].a2;
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].e1a, vecs[i].e2a, vecs[i].e1b, vecs[i].e2b);
        end

        // Async reset between edges: R3=AA, then RESET pulse clears it without a clock edge.
        @(negedge clk);
        wr = 1'b1; busy = 1'b0; din = 8'hAA; waddr = 3'd3; a1 = 3'd3; a2 = 3'd5;
        @(negedge clk);
        wr = 1'b0;
        #1;
        check_all("async pre", 8'hAA, 8'h3C, 8'hAA, 8'h3C);
        #1 rst = 1'b1;
        #1;
        check_all("async rst", 8'h00, 8'h00, 8'h00, 8'h00);
        #1 rst = 1'b0;
        @(negedge clk);
        a2 = 3'd1;
        #1;
        check_all("async post", 8'h00, 8'h00, 8'h00, 8'h00);

        // Reset held across an edge with a write pending: write is lost, no forwarding.
        @(negedge clk);
        wr = 1'b1; din = 8'h55; waddr = 3'd6; a1 = 3'd6; a2 = 3'd6;
        #1;
        check_all("rstwr fwd", 8'h00, 8'h00, 8'h55, 8'h55);
        #1 rst = 1'b1;
        #1;
        check_all("rstwr held", 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        rst = 1'b0; wr = 1'b0;
        #1;
        check_all("rstwr post", 8'h00, 8'h00, 8'h00, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
